// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter.
//   src_t   : which requester drives the memory port (none / fetch / data read / data write)
//   state_t : arbiter state, free arbitration or grant held for one source
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DR   = 2'd2,
        SRC_DW   = 2'd3
    } src_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the memory arbiter.
// Ports:
//   if_req, dr_req, dw_req : current requests from fetch, data read, data write
//   starve                 : fetch has waited too long; fetch takes top priority
//   src                    : winning source, SRC_NONE when nothing requests
// Normal order is DW > DR > IF; while starving it is IF > DW > DR.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dr_req,
    input  logic dw_req,
    input  logic starve,
    output src_t src
);

    always_comb begin
        src = SRC_NONE;
        if (starve && if_req) begin
            src = SRC_IF;
        end else if (dw_req) begin
            src = SRC_DW;
        end else if (dr_req) begin
            src = SRC_DR;
        end else if (if_req) begin
            src = SRC_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF),
// data read (DR) and data write (DW).
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   i_ready/i_addr                 : fetch request; i_valid accept pulse, i_rresp/i_rdata response
//   dr_ready/dr_addr               : data read request; dr_valid, dr_rresp/dr_rdata
//   dw_ready/dw_addr/dw_wdata/dw_wstrb : data write request; dw_valid accept pulse
//   m_ready/m_we/m_addr/m_wdata/m_wstrb : request toward memory
//   m_valid                        : memory accepts the driven request this cycle
//   m_rresp/m_rdata                : read response, one cycle after an accepted read
// Grants are zero-latency; an unaccepted grant is locked until accepted or abandoned.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_ready,
    input  logic [AW-1:0]   i_addr,
    output logic            i_valid,
    output logic            i_rresp,
    output logic [DW-1:0]   i_rdata,
    input  logic            dr_ready,
    input  logic [AW-1:0]   dr_addr,
    output logic            dr_valid,
    output logic            dr_rresp,
    output logic [DW-1:0]   dr_rdata,
    input  logic            dw_ready,
    input  logic [AW-1:0]   dw_addr,
    input  logic [DW-1:0]   dw_wdata,
    input  logic [DW/8-1:0] dw_wstrb,
    output logic            dw_valid,
    output logic            m_ready,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_valid,
    input  logic            m_rresp,
    input  logic [DW-1:0]   m_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_t        state;
    src_t          lock_src;
    src_t          rsp_src;
    logic          rsp_pend;
    logic [CW-1:0] starve_cnt;

    src_t pick_src;
    src_t drv_src;
    logic starve;
    logic lock_req;
    logic accept;
    logic read_accept;

    assign starve = (starve_cnt == CW'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .if_req (i_ready),
        .dr_req (dr_ready),
        .dw_req (dw_ready),
        .starve (starve),
        .src    (pick_src)
    );

    // Is the locked requester still asking?
    always_comb begin
        lock_req = 1'b0;
        case (lock_src)
            SRC_IF:  lock_req = i_ready;
            SRC_DR:  lock_req = dr_ready;
            SRC_DW:  lock_req = dw_ready;
            default: lock_req = 1'b0;
        endcase
    end

    // Source driving the memory port this cycle; forced to none during reset
    // so every combinational output is quiet while reset is high.
    always_comb begin
        drv_src = SRC_NONE;
        if (!reset) begin
            if (state == ST_LOCK) begin
                drv_src = lock_req ? lock_src : SRC_NONE;
            end else begin
                drv_src = pick_src;
            end
        end
    end

    assign accept      = m_valid && (drv_src != SRC_NONE);
    assign read_accept = accept && ((drv_src == SRC_IF) || (drv_src == SRC_DR));

    // Memory-side request mux
    always_comb begin
        m_ready = (drv_src != SRC_NONE);
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        case (drv_src)
            SRC_IF:  m_addr = i_addr;
            SRC_DR:  m_addr = dr_addr;
            SRC_DW: begin
                m_we    = 1'b1;
                m_addr  = dw_addr;
                m_wdata = dw_wdata;
                m_wstrb = dw_wstrb;
            end
            default: m_addr = '0;
        endcase
    end

    assign i_valid  = accept && (drv_src == SRC_IF);
    assign dr_valid = accept && (drv_src == SRC_DR);
    assign dw_valid = accept && (drv_src == SRC_DW);

    // Read data arrives the cycle after acceptance; steer it by the tag
    // captured at acceptance, the non-owning port sees zero.
    always_comb begin
        i_rresp  = 1'b0;
        i_rdata  = '0;
        dr_rresp = 1'b0;
        dr_rdata = '0;
        if (!reset && rsp_pend) begin
            if (rsp_src == SRC_IF) begin
                i_rresp = m_rresp;
                i_rdata = m_rdata;
            end else if (rsp_src == SRC_DR) begin
                dr_rresp = m_rresp;
                dr_rdata = m_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lock_src   <= SRC_NONE;
            rsp_src    <= SRC_NONE;
            rsp_pend   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((drv_src != SRC_NONE) && !m_valid) begin
                        state    <= ST_LOCK;
                        lock_src <= drv_src;
                    end
                end
                ST_LOCK: begin
                    // Leave on acceptance or when the requester gives up
                    if (accept || !lock_req) begin
                        state    <= ST_IDLE;
                        lock_src <= SRC_NONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    lock_src <= SRC_NONE;
                end
            endcase

            rsp_pend <= read_accept;
            rsp_src  <= read_accept ? drv_src : SRC_NONE;

            if (!i_ready || i_valid) begin
                starve_cnt <= '0;
            end else if (!starve) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of per-cycle vectors plus
// hand-written starvation and reset sequences; read responses are tracked
// in a scoreboard queue and checked in the cycle they are due.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DADDR = 32'h0000_0100;
    localparam logic [31:0] WADDR = 32'h0000_2000;
    localparam logic [31:0] WDATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  WSTRB = 4'b0110;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_ready, dr_ready, dw_ready, m_valid, m_rresp;
    logic [31:0] i_addr, dr_addr, dw_addr, dw_wdata, m_rdata;
    logic [3:0]  dw_wstrb;
    logic        i_valid, i_rresp, dr_valid, dr_rresp, dw_valid, m_ready, m_we;
    logic [31:0] i_rdata, dr_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_ready(i_ready), .i_addr(i_addr), .i_valid(i_valid), .i_rresp(i_rresp), .i_rdata(i_rdata),
        .dr_ready(dr_ready), .dr_addr(dr_addr), .dr_valid(dr_valid), .dr_rresp(dr_rresp), .dr_rdata(dr_rdata),
        .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_wstrb(dw_wstrb), .dw_valid(dw_valid),
        .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_valid(m_valid), .m_rresp(m_rresp), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        src_t        src;
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic        i, dr, dw, mv;
        src_t        exp;
        logic [31:0] data;
    } vec_t;

    rsp_t        exp_q[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        pend   = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] addr_of(input src_t s);
        case (s)
            SRC_IF:  return IADDR;
            SRC_DR:  return DADDR;
            SRC_DW:  return WADDR;
            default: return 32'h0;
        endcase
    endfunction

    // Memory model: deliver planned read data the cycle after a read accept,
    // otherwise present junk that must never reach a requester.
    task automatic drive_mem();
        if (pend) begin
            m_rdata = pend_data;
            m_rresp = 1'b1;
        end else begin
            m_rdata = $urandom;
            m_rresp = 1'($urandom_range(0, 1));
        end
        pend = 1'b0;
    endtask

    task automatic check_rsp();
        logic [31:0] ei, ed;
        logic        ri, rd;
        ei = '0; ed = '0; ri = 1'b0; rd = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            rsp_t r;
            r = exp_q.pop_front();
            if (r.src == SRC_IF) begin
                ei = r.data; ri = 1'b1;
            end else begin
                ed = r.data; rd = 1'b1;
            end
        end
        chk("i_rresp", i_rresp, ri);
        chk("i_rdata", i_rdata, ei);
        chk("dr_rresp", dr_rresp, rd);
        chk("dr_rdata", dr_rdata, ed);
    endtask

    // One clock cycle: drive requests, check the grant/port mux and any due response.
    task automatic cycle(input logic i, input logic dr, input logic dw, input logic mv,
                         input src_t exp, input logic [31:0] data);
        drive_mem();
        i_ready = i; dr_ready = dr; dw_ready = dw; m_valid = mv;
        #2;
        chk("m_ready", m_ready, exp != SRC_NONE);
        chk("m_we", m_we, exp == SRC_DW);
        chk("m_addr", m_addr, addr_of(exp));
        chk("m_wdata", m_wdata, (exp == SRC_DW) ? WDATA : 32'h0);
        chk("m_wstrb", m_wstrb, (exp == SRC_DW) ? WSTRB : 4'h0);
        chk("valid_if_dr_dw", {i_valid, dr_valid, dw_valid},
            mv ? {exp == SRC_IF, exp == SRC_DR, exp == SRC_DW} : 3'b000);
        check_rsp();
        if (mv && (exp == SRC_IF || exp == SRC_DR)) begin
            pend      = 1'b1;
            pend_data = data;
            exp_q.push_back('{exp, data, cyc + 1});
        end
        $display("cyc %0d req if/dr/dw=%b%b%b m_valid=%b expect=%s m_addr=%h",
                 cyc, i, dr, dw, mv, exp.name(), m_addr);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_ctl"}, {m_ready, m_we, i_valid, dr_valid, dw_valid, i_rresp, dr_rresp}, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wr"}, {m_wstrb, m_wdata}, 0);
        chk({tag, "_rdata"}, {i_rdata, dr_rdata}, 0);
    endtask

    // Assert reset in the middle of the current cycle with live requests,
    // hold it across one edge, release just after the edge.
    task automatic rst_mid();
        reset = 1'b1;
        dw_ready = 1'b1; m_valid = 1'b1; m_rresp = 1'b1; m_rdata = 32'hFFFF_0000;
        #1;
        rst_check("rst_now");
        exp_q.delete();
        pend = 1'b0;
        @(posedge clk);
        #1;
        rst_check("rst_hold");
        chk("rst_regs", {dut.state, dut.rsp_pend, dut.starve_cnt}, 0);
        $display("cyc %0d reset pulse", cyc);
        reset = 1'b0;
        cyc++;
    endtask

    initial begin
        i_addr = IADDR; dr_addr = DADDR; dw_addr = WADDR; dw_wdata = WDATA; dw_wstrb = WSTRB;

        // Simultaneous requests: DW, DR, IF on consecutive accepts
        vecs.push_back('{1, 1, 1, 1, SRC_DW,   32'h0});
        vecs.push_back('{1, 1, 0, 1, SRC_DR,   32'h1111_2222});
        vecs.push_back('{1, 0, 0, 1, SRC_IF,   32'h3333_4444});
        vecs.push_back('{0, 0, 0, 1, SRC_NONE, 32'h0});
        // Lock hold: DR locked at 0x100, DW arrives and waits
        vecs.push_back('{0, 1, 0, 0, SRC_DR,   32'h0});
        vecs.push_back('{0, 1, 1, 0, SRC_DR,   32'h0});
        vecs.push_back('{0, 1, 1, 0, SRC_DR,   32'h0});
        vecs.push_back('{0, 1, 1, 1, SRC_DR,   32'h5A5A_0100});
        vecs.push_back('{0, 0, 1, 1, SRC_DW,   32'h0});
        vecs.push_back('{0, 0, 0, 0, SRC_NONE, 32'h0});
        // Lock abandon: IF locks, then withdraws while memory is ready
        vecs.push_back('{1, 0, 0, 0, SRC_IF,   32'h0});
        vecs.push_back('{0, 0, 0, 1, SRC_NONE, 32'h0});
        vecs.push_back('{0, 1, 0, 1, SRC_DR,   32'h7777_0000});
        vecs.push_back('{0, 0, 0, 0, SRC_NONE, 32'h0});
        // Response routing and back-to-back alternating reads
        vecs.push_back('{1, 0, 0, 1, SRC_IF,   32'hAAAA_0000});
        vecs.push_back('{0, 1, 0, 1, SRC_DR,   32'hBBBB_0000});
        vecs.push_back('{1, 1, 0, 1, SRC_DR,   32'hCCCC_0001});
        vecs.push_back('{1, 0, 0, 1, SRC_IF,   32'hDDDD_0002});
        vecs.push_back('{0, 0, 0, 0, SRC_NONE, 32'h0});

        // Reset held with live requests: everything quiet
        reset = 1'b1;
        i_ready = 1'b1; dr_ready = 1'b1; dw_ready = 1'b1; m_valid = 1'b1;
        m_rresp = 1'b1; m_rdata = 32'hFFFF_FFFF;
        #2;
        rst_check("rst_init");
        @(posedge clk);
        #1;
        rst_check("rst_init2");
        reset = 1'b0;

        foreach (vecs[k])
            cycle(vecs[k].i, vecs[k].dr, vecs[k].dw, vecs[k].mv, vecs[k].exp, vecs[k].data);

        // Starvation guard: DW wins four times, then fetch
        for (int k = 0; k < 4; k++)
            cycle(1, 0, 1, 1, SRC_DW, 32'h0);
        chk("starve_cnt_sat", dut.starve_cnt, 4);
        cycle(1, 0, 1, 1, SRC_IF, 32'h9999_0005);
        chk("starve_cnt_clr", dut.starve_cnt, 0);
        cycle(0, 0, 1, 1, SRC_DW, 32'h0);
        cycle(0, 0, 0, 0, SRC_NONE, 32'h0);

        // Reset with a read response pending
        cycle(0, 1, 0, 1, SRC_DR, 32'h1234_5678);
        drive_mem();
        i_ready = 1'b1; dr_ready = 1'b0; dw_ready = 1'b0; m_valid = 1'b0;
        #2;
        rst_mid();
        cycle(0, 0, 0, 0, SRC_NONE, 32'h0);
        // Reset while locked on IF
        cycle(1, 0, 0, 0, SRC_IF, 32'h0);
        drive_mem();
        i_ready = 1'b1; m_valid = 1'b0;
        #2;
        rst_mid();
        cycle(0, 1, 0, 1, SRC_DR, 32'h5555_AAAA);
        cycle(0, 0, 0, 0, SRC_NONE, 32'h0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
